// File: rtl/fifo_token_packer_if.sv
// Handshake bundle between fifo_token_packer and its upstream/downstream FIFOs.
// FIFO_TOKEN_PACKER_FLUSH_EN adds the flush request and the out_tokens count.
interface fifo_token_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int TOK_W = $clog2(RATIO + 1);

  logic             in_empty_n;
  logic [IN_W-1:0]  in_dout;
  logic             in_read;
  logic             out_full_n;
  logic [OUT_W-1:0] out_din;
  logic             out_write;
`ifdef FIFO_TOKEN_PACKER_FLUSH_EN
  logic             flush;
  logic [TOK_W-1:0] out_tokens;

  modport slave (
    input  in_empty_n, in_dout, out_full_n, flush,
    output in_read, out_din, out_write, out_tokens
  );
  modport master (
    output in_empty_n, in_dout, out_full_n, flush,
    input  in_read, out_din, out_write, out_tokens
  );
`else
  modport slave (
    input  in_empty_n, in_dout, out_full_n,
    output in_read, out_din, out_write
  );
  modport master (
    output in_empty_n, in_dout, out_full_n,
    input  in_read, out_din, out_write
  );
`endif
endinterface

// File: rtl/fifo_token_packer.sv
// Packs RATIO narrow FIFO tokens (little-endian) into one wide word for a downstream FIFO.
// Optional partial-word flush is enabled by defining FIFO_TOKEN_PACKER_FLUSH_EN.
module fifo_token_packer #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
) (
  input  logic               clk,
  input  logic               ap_rst_n,
  fifo_token_packer_if.slave bus
);
  localparam int OUT_W = IN_W * RATIO;
  localparam int IDX_W = $clog2(RATIO);
  localparam int TOK_W = $clog2(RATIO + 1);
  localparam int LOW_W = (RATIO - 1) * IN_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HELD  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [OUT_W-1:0] r_pack;
  logic [OUT_W-1:0] r_hold;
  logic [OUT_W-1:0] w_pack_nxt;
  logic             w_hold_valid;
  logic             w_out_write;
  logic             w_in_read;
  logic             w_complete;
  logic             w_flush_fire;
  logic             w_load;

  // Handshake decode; both strobes are gated by reset so they drop the moment it asserts.
  always_comb begin
    w_hold_valid = (r_state == S_HELD);
    w_out_write  = ap_rst_n & w_hold_valid & bus.out_full_n;
`ifdef FIFO_TOKEN_PACKER_FLUSH_EN
    w_in_read    = ap_rst_n & bus.in_empty_n & ~bus.flush &
                   ((r_idx != IDX_LAST) | ~w_hold_valid | w_out_write);
    w_flush_fire = ap_rst_n & bus.flush & (r_idx != IDX_ZERO) &
                   (~w_hold_valid | w_out_write) & ~w_in_read;
`else
    w_in_read    = ap_rst_n & bus.in_empty_n &
                   ((r_idx != IDX_LAST) | ~w_hold_valid | w_out_write);
    w_flush_fire = 1'b0;
`endif
    w_complete   = w_in_read & (r_idx == IDX_LAST);
    w_load       = w_complete | w_flush_fire;
  end

  // Pack register with the incoming token dropped into the slot selected by r_idx.
  always_comb begin
    w_pack_nxt = r_pack;
    for (int k = 0; k < RATIO; k++) begin
      w_pack_nxt[k*IN_W +: IN_W] = (r_idx == IDX_W'(k)) ? bus.in_dout : r_pack[k*IN_W +: IN_W];
    end
  end

  // Next hold-register state: a new load always wins over a drain in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_load) begin
          w_state_nxt = S_HELD;
        end else begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_HELD: begin
        if (w_load) begin
          w_state_nxt = S_HELD;
        end else if (w_out_write) begin
          w_state_nxt = S_EMPTY;
        end else begin
          w_state_nxt = S_HELD;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Hold-register occupancy state.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Token accumulation and word hand-off into the hold register.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_idx  <= IDX_ZERO;
      r_pack <= {OUT_W{1'b0}};
      r_hold <= {OUT_W{1'b0}};
    end else if (w_complete) begin
      r_hold <= {bus.in_dout, r_pack[LOW_W-1:0]};
      r_pack <= {OUT_W{1'b0}};
      r_idx  <= IDX_ZERO;
    end else if (w_in_read) begin
      r_pack <= w_pack_nxt;
      r_idx  <= r_idx + IDX_W'(1);
    end else if (w_flush_fire) begin
      // Unfilled slots of r_pack are already zero, giving the zero padding for free.
      r_hold <= r_pack;
      r_pack <= {OUT_W{1'b0}};
      r_idx  <= IDX_ZERO;
    end else begin
      r_idx  <= r_idx;
      r_pack <= r_pack;
      r_hold <= r_hold;
    end
  end

`ifdef FIFO_TOKEN_PACKER_FLUSH_EN
  logic [TOK_W-1:0] r_tokens;

  // Valid-token count that travels alongside the held word.
  always_ff @(posedge clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_tokens <= {TOK_W{1'b0}};
    end else if (w_complete) begin
      r_tokens <= TOK_W'(RATIO);
    end else if (w_flush_fire) begin
      r_tokens <= TOK_W'(r_idx);
    end else begin
      r_tokens <= r_tokens;
    end
  end

  assign bus.out_tokens = r_tokens;
`endif

  assign bus.in_read   = w_in_read;
  assign bus.out_write = w_out_write;
  assign bus.out_din   = r_hold;
endmodule
